// File: rtl/vga_bridge_pkg.sv
// vga_bridge_pkg: shared state type, port offsets and bit map for the VGA pointer bridge
package vga_bridge_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_e;
  localparam logic [7:0] OFS_ADDR = 8'd0;
  localparam logic [7:0] OFS_DATA = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;
  localparam int CTRL_AI = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int STAT_VS = 0;
  localparam int STAT_BUSY = 1;
  localparam int STAT_DROP = 2;
  localparam int STAT_FRAME = 4;
  function automatic logic [7:0] status_byte(input logic [3:0] frame, input logic drop,
                                             input logic busy, input logic vs_low);
    status_byte = '0;
    status_byte[STAT_FRAME +: 4] = frame;
    status_byte[STAT_DROP] = drop;
    status_byte[STAT_BUSY] = busy;
    status_byte[STAT_VS] = vs_low;
  endfunction
endpackage

// File: rtl/vga_shadow_regs.sv
// vga_shadow_regs: shadow entry array with per-entry dirty mask, one write, one read, one dirty-clear port
module vga_shadow_regs #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_dirty
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DATA_W-1:0] shadow_d [DEPTH];
  logic [DEPTH-1:0]  dirty_q, dirty_d;
  assign rd_data  = shadow_q[rd_addr];
  assign rd_dirty = dirty_q[rd_addr];
  // a write to the entry being cleared leaves it dirty
  always_comb begin
    shadow_d = shadow_q;
    dirty_d = dirty_q;
    if (clr_en) dirty_d[clr_addr] = 1'b0;
    if (wr_en) begin
      shadow_d[wr_addr] = wr_data;
      dirty_d[wr_addr] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
      dirty_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q <= dirty_d;
    end
  end
endmodule

// File: rtl/vga_port_bridge.sv
// vga_port_bridge: Picoblaze port bridge that shadows pointer-memory writes and flushes dirty entries on VSync fall
module vga_port_bridge #(
  parameter logic [7:0] BASE_PORT   = 8'd40,
  parameter logic [7:0] STATUS_PORT = 8'd2,
  parameter int         ADDR_W      = 4,
  parameter int         DATA_W      = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        Port_ID,
  input  logic [7:0]        IN_DATA,
  input  logic              Write_Strobe,
  input  logic              Read_Strobe,
  input  logic              VSync,
  output logic [7:0]        OUT_DATA,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemData,
  output logic              Write,
  output logic              Busy
);
  import vga_bridge_pkg::*;
  localparam int DEPTH = 2**ADDR_W;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, idx_q, idx_d, mem_addr_q, mem_addr_d, rd_addr;
  logic [DATA_W-1:0] mem_data_q, mem_data_d, rd_data;
  logic [3:0]        frame_q, frame_d;
  logic              ai_q, ai_d, drop_q, drop_d, write_q, write_d, vs_q;
  logic              p_addr, p_data, p_ctrl, rd_stat, rd_port, commit_req;
  logic              busy, vs_fall, data_ok, drop_evt, flush_wr, rd_dirty;
  assign busy       = state_q != IDLE;
  assign vs_fall    = vs_q & ~VSync;
  assign p_addr     = Write_Strobe && Port_ID == BASE_PORT + OFS_ADDR;
  assign p_data     = Write_Strobe && Port_ID == BASE_PORT + OFS_DATA;
  assign p_ctrl     = Write_Strobe && Port_ID == BASE_PORT + OFS_CTRL;
  assign rd_stat    = Read_Strobe && Port_ID == STATUS_PORT;
  assign rd_port    = Read_Strobe && Port_ID == BASE_PORT + OFS_DATA;
  assign commit_req = p_ctrl && IN_DATA[CTRL_COMMIT];
  assign data_ok    = p_data && !busy;
  assign drop_evt   = busy && (p_data || commit_req);
  assign flush_wr   = state_q == FLUSH && rd_dirty;
  // CPU writes are locked out while busy, so the read port is free to walk idx during FLUSH
  assign rd_addr    = state_q == FLUSH ? idx_q : ptr_q;
  assign OUT_DATA   = rd_stat ? status_byte(frame_q, drop_q, busy, ~VSync)
                    : rd_port ? 8'(rd_data) : 8'hFF;
  assign MemAddr    = mem_addr_q;
  assign MemData    = mem_data_q;
  assign Write      = write_q;
  assign Busy       = busy;
  vga_shadow_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_regs (
    .clk      (CLK),
    .rst_n    (RESET),
    .wr_en    (data_ok),
    .wr_addr  (ptr_q),
    .wr_data  (IN_DATA[DATA_W-1:0]),
    .clr_en   (flush_wr),
    .clr_addr (idx_q),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_dirty (rd_dirty)
  );
  always_comb begin
    ptr_d = p_addr ? IN_DATA[ADDR_W-1:0] : (data_ok && ai_q) ? ptr_q + ADDR_W'(1) : ptr_q;
    ai_d = p_ctrl ? IN_DATA[CTRL_AI] : ai_q;
    drop_d = drop_evt | (drop_q & ~rd_stat);
    frame_d = frame_q + {3'b000, vs_fall};
    idx_d = state_q == FLUSH ? idx_q + ADDR_W'(1) : '0;
    state_d = state_q == IDLE  ? (commit_req ? ARMED : IDLE)
            : state_q == ARMED ? (vs_fall ? FLUSH : ARMED)
            : (idx_q == ADDR_W'(DEPTH-1) ? IDLE : FLUSH);
    write_d = flush_wr;
    mem_addr_d = flush_wr ? idx_q : mem_addr_q;
    mem_data_d = flush_wr ? rd_data : mem_data_q;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      ai_q <= 1'b1;
      drop_q <= 1'b0;
      frame_q <= '0;
      vs_q <= 1'b1;
      write_q <= 1'b0;
      mem_addr_q <= '1;
      mem_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      ai_q <= ai_d;
      drop_q <= drop_d;
      frame_q <= frame_d;
      vs_q <= VSync;
      write_q <= write_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end
endmodule

// File: tb/tb_vga_port_bridge.sv
// tb_vga_port_bridge: directed stimulus with queued expectations checked by a negedge monitor
module tb_vga_port_bridge;
  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] Port_ID = 8'd0;
  logic [7:0] IN_DATA = 8'd0;
  logic       Write_Strobe = 1'b0;
  logic       Read_Strobe = 1'b0;
  logic       VSync = 1'b1;
  logic [7:0] OUT_DATA;
  logic [3:0] MemAddr;
  logic [7:0] MemData;
  logic       Write;
  logic       Busy;
  typedef struct {int cyc; logic [3:0] addr; logic [7:0] data;} wexp_t;
  wexp_t      wq[$];
  wexp_t      e;
  logic [7:0] rq[$];
  logic [7:0] r;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         c;
  vga_port_bridge dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Port_ID      (Port_ID),
    .IN_DATA      (IN_DATA),
    .Write_Strobe (Write_Strobe),
    .Read_Strobe  (Read_Strobe),
    .VSync        (VSync),
    .OUT_DATA     (OUT_DATA),
    .MemAddr      (MemAddr),
    .MemData      (MemData),
    .Write        (Write),
    .Busy         (Busy)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  always @(negedge CLK) begin
    if (Write) begin
      n_cmp++;
      if (wq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: cyc=%0d addr=%h data=%h, none expected", cyc, MemAddr, MemData);
      end else begin
        e = wq.pop_front();
        if (cyc != e.cyc || MemAddr !== e.addr || MemData !== e.data) begin
          n_bad++;
          $display("FAIL mem_write: got cyc=%0d addr=%h data=%h, expected cyc=%0d addr=%h data=%h",
                   cyc, MemAddr, MemData, e.cyc, e.addr, e.data);
        end
      end
    end
    if (Read_Strobe) begin
      n_cmp++;
      if (rq.size() == 0) begin
        n_bad++;
        $display("FAIL read_scoreboard: read with no expectation, port=%0d", Port_ID);
      end else begin
        r = rq.pop_front();
        if (OUT_DATA !== r) begin
          n_bad++;
          $display("FAIL read_port%0d: got %h expected %h", Port_ID, OUT_DATA, r);
        end
      end
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    Port_ID = p;
    IN_DATA = d;
    Write_Strobe = 1'b1;
    tick();
    Write_Strobe = 1'b0;
  endtask
  task automatic rd(input logic [7:0] p, input logic [7:0] exp);
    rq.push_back(exp);
    Port_ID = p;
    Read_Strobe = 1'b1;
    tick();
    Read_Strobe = 1'b0;
  endtask
  task automatic expect_wr(input int at, input logic [3:0] a, input logic [7:0] d);
    wexp_t x;
    x.cyc = at;
    x.addr = a;
    x.data = d;
    wq.push_back(x);
  endtask
  initial begin
    ticks(3);
    chk("reset_memaddr", 32'(MemAddr), 32'hF);
    chk("reset_memdata", 32'(MemData), 32'h0);
    chk("reset_write", 32'(Write), 32'h0);
    chk("reset_busy", 32'(Busy), 32'h0);
    RESET = 1'b1;
    tick();
    rd(8'd2, 8'h00);
    rd(8'd41, 8'h00);
    Port_ID = 8'd2;
    #1 chk("no_strobe_ff", 32'(OUT_DATA), 32'hFF);
    // basic shadow writes with auto-increment
    wr(8'd40, 8'h03);
    wr(8'd41, 8'hAA);
    wr(8'd41, 8'hBB);
    rd(8'd41, 8'h00);
    wr(8'd40, 8'h03);
    rd(8'd41, 8'hAA);
    rd(8'd41, 8'hAA);
    wr(8'd40, 8'h04);
    rd(8'd41, 8'hBB);
    wr(8'd40, 8'h05);
    // commit, then drops while armed
    wr(8'd42, 8'h03);
    chk("busy_armed", 32'(Busy), 32'h1);
    rd(8'd2, 8'h02);
    wr(8'd41, 8'h77);
    rd(8'd2, 8'h06);
    rd(8'd2, 8'h02);
    wr(8'd42, 8'h03);
    rd(8'd2, 8'h06);
    rd(8'd2, 8'h02);
    // flush of entries 3 and 4
    VSync = 1'b0;
    c = cyc;
    expect_wr(c + 5, 4'h3, 8'hAA);
    expect_wr(c + 6, 4'h4, 8'hBB);
    ticks(3);
    VSync = 1'b1;
    ticks(13);
    chk("busy_last_flush", 32'(Busy), 32'h1);
    tick();
    chk("busy_done", 32'(Busy), 32'h0);
    rd(8'd2, 8'h10);
    rd(8'd41, 8'h00);
    // empty commit: no pulses, status with VSync low
    wr(8'd42, 8'h03);
    VSync = 1'b0;
    tick();
    rd(8'd2, 8'h23);
    VSync = 1'b1;
    ticks(20);
    rd(8'd7, 8'hFF);
    rd(8'd2, 8'h20);
    // pointer wrap and auto-increment off
    wr(8'd40, 8'h0F);
    wr(8'd41, 8'h11);
    wr(8'd41, 8'h22);
    wr(8'd40, 8'h00);
    rd(8'd41, 8'h22);
    wr(8'd40, 8'h0F);
    rd(8'd41, 8'h11);
    wr(8'd42, 8'h00);
    wr(8'd40, 8'h07);
    wr(8'd41, 8'h33);
    wr(8'd41, 8'h44);
    rd(8'd41, 8'h44);
    wr(8'd42, 8'h02);
    VSync = 1'b0;
    c = cyc;
    expect_wr(c + 2, 4'h0, 8'h22);
    expect_wr(c + 9, 4'h7, 8'h44);
    expect_wr(c + 17, 4'hF, 8'h11);
    ticks(3);
    VSync = 1'b1;
    ticks(16);
    chk("busy_after_wrap_flush", 32'(Busy), 32'h0);
    rd(8'd2, 8'h30);
    // reset while flushing idx 2
    wr(8'd42, 8'h01);
    wr(8'd40, 8'h01);
    wr(8'd41, 8'h51);
    wr(8'd41, 8'h52);
    wr(8'd41, 8'h53);
    wr(8'd42, 8'h03);
    VSync = 1'b0;
    c = cyc;
    expect_wr(c + 3, 4'h1, 8'h51);
    tick();
    VSync = 1'b1;
    ticks(2);
    @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    chk("abort_write", 32'(Write), 32'h0);
    chk("abort_memaddr", 32'(MemAddr), 32'hF);
    chk("abort_memdata", 32'(MemData), 32'h0);
    chk("abort_busy", 32'(Busy), 32'h0);
    ticks(2);
    RESET = 1'b1;
    ticks(20);
    rd(8'd2, 8'h00);
    rd(8'd41, 8'h00);
    chk("pending_writes", 32'(wq.size()), 32'h0);
    chk("pending_reads", 32'(rq.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_port_bridge.md
VGA_PORT_BRIDGE -- requirements
Module: vga_port_bridge

Interface
REQ-001 Parameter BASE_PORT, default 8'd40, first of three consecutive write/read port IDs (ADDR, DATA, CTRL at BASE_PORT+0/+1/+2).
REQ-002 Parameter STATUS_PORT, default 8'd2, read-only status port ID.
REQ-003 Parameter ADDR_W, default 4, shadow address width; DEPTH = 2**ADDR_W entries.
REQ-004 Parameter DATA_W, default 8, entry width, legal range 1..8.
REQ-005 CLK  in  1  single clock, all logic on rising edge.
REQ-006 RESET  in  1  asynchronous, active-low reset; asserted at 0.
REQ-007 Port_ID  in  8  Picoblaze port address.
REQ-008 IN_DATA  in  8  Picoblaze write data.
REQ-009 Write_Strobe  in  1  Picoblaze write qualifier, one cycle.
REQ-010 Read_Strobe  in  1  Picoblaze read qualifier, one cycle.
REQ-011 VSync  in  1  vertical sync from sync counters, active-low.
REQ-012 OUT_DATA  out  8  combinational read data to Picoblaze.
REQ-013 MemAddr  out  ADDR_W  registered address to pointer memory.
REQ-014 MemData  out  DATA_W  registered data to pointer memory.
REQ-015 Write  out  1  registered one-cycle write pulse to pointer memory.
REQ-016 Busy  out  1  high in states ARMED and FLUSH.

Function
REQ-017 Internal state: shadow array DEPTH x DATA_W, dirty bitmask DEPTH bits, address pointer ptr (ADDR_W), auto-increment bit ai, sticky drop flag, 4-bit frame counter, registered vs_q.
REQ-018 Write to BASE_PORT+0: ptr <= IN_DATA[ADDR_W-1:0].
REQ-019 Write to BASE_PORT+1 in IDLE: shadow[ptr] <= IN_DATA[DATA_W-1:0], dirty[ptr] <= 1, ptr <= ptr+1 if ai (wraps DEPTH-1 -> 0).
REQ-020 Write to BASE_PORT+2: ai <= IN_DATA[0]; IN_DATA[1]=1 in IDLE requests commit (IDLE -> ARMED).
REQ-021 Writes to BASE_PORT+1 or commit requests while Busy are dropped and set the sticky drop flag; ptr/ai writes always accepted.
REQ-022 Writes to any other Port_ID have no effect; Write stays 0.
REQ-023 Read, Port_ID==STATUS_PORT and Read_Strobe: OUT_DATA = {frame[3:0], 1'b0, drop, Busy, ~VSync}.
REQ-024 Read, Port_ID==BASE_PORT+1 and Read_Strobe: OUT_DATA = shadow[ptr] zero-extended; no auto-increment on read.
REQ-025 Any other read, or Read_Strobe low: OUT_DATA = 8'hFF.
REQ-026 Status read (Read_Strobe at STATUS_PORT) clears drop on the next edge; a simultaneous drop event wins (flag stays 1).
REQ-027 VSync falling edge = vs_q==1 and VSync==0; frame increments mod 16 on each falling edge in every state.
REQ-028 States: IDLE, ARMED, FLUSH; ARMED -> FLUSH on falling edge, idx <= 0.
REQ-029 FLUSH lasts exactly DEPTH cycles, idx 0..DEPTH-1; each cycle, if dirty[idx]: MemAddr <= idx, MemData <= shadow[idx], Write <= 1, dirty[idx] <= 0; else Write <= 0 and MemAddr/MemData hold.
REQ-030 After idx==DEPTH-1, FLUSH -> IDLE; entry i write pulse is visible in cycle N+2+i, N being the cycle the falling edge is sampled.
REQ-031 Commit with no dirty entries still traverses ARMED and FLUSH; no Write pulse issued.
REQ-032 Write is never high outside FLUSH; at most one pulse per cycle.

Reset
REQ-033 RESET low: state IDLE, ptr 0, ai 1, shadow 0, dirty 0, drop 0, frame 0, vs_q 1, MemAddr all ones, MemData 0, Write 0, Busy 0.
REQ-034 RESET mid-FLUSH aborts immediately; no further Write pulses; unflushed entries lost.

Structure
REQ-035 Package vga_bridge_pkg holds state enum, port offsets (ADDR/DATA/CTRL), CTRL and status bit positions.
REQ-036 One sub-module vga_shadow_regs: shadow array plus dirty mask, one write port, one combinational read port, one clear-dirty port.

Verification
REQ-037 Write 0x03 to port 40, 0xAA,0xBB to port 41 -> shadow[3]=0xAA, shadow[4]=0xBB, ptr=5; read port 41 returns 0xAA after ptr reset to 3.
REQ-038 ptr=15, ai=1, write 0x11 to port 41 -> ptr wraps to 0.
REQ-039 Dirty entries 3,4; write 0x02 to port 42; VSync falls at cycle N -> Write high in N+5 (addr 3, 0xAA) and N+6 (addr 4, 0xBB) only; Busy low after N+17.
REQ-040 Write port 41 while Busy -> shadow unchanged, status bit2=1; status read then clears it.
REQ-041 RESET low during FLUSH at idx 2 -> Write 0 at once, MemAddr 0xF, state IDLE.
REQ-042 Read port 2 with VSync low -> OUT_DATA[0]=1; read port 7 -> 8'hFF.
